// File: rtl/crossbar_route_ctrl_pkg.sv
// Shared state encoding, error codes and widths for crossbar_route_ctrl.
// Optional build macro used by the top: ROUTE_CACHE_EN.
package crossbar_route_ctrl_pkg;

  localparam int CTRL_W = 5;
  localparam int SEL_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DUP     = 2'd1;
  localparam logic [1:0] ERR_UNROUTE = 2'd2;

  // A map that names the same source twice can never be a crossbar setting.
  function automatic logic sel_has_dup(input logic [SEL_W-1:0] sel);
    logic dup;
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (sel[2*i +: 2] == sel[2*j +: 2]) dup = 1'b1;
      end
    end
    return dup;
  endfunction

endpackage

// File: rtl/crossbar_route_ctrl_if.sv
// Request/response bundle of crossbar_route_ctrl; slave = the controller side.
interface crossbar_route_ctrl_if;
  import crossbar_route_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  req_sel;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_ok;
  logic [1:0]        resp_err;
  logic [CTRL_W-1:0] resp_ctrl;
  logic [CTRL_W-1:0] xbar_ctrl;

  modport slave (
    input  req_valid, req_sel, resp_ready,
    output req_ready, resp_valid, resp_ok, resp_err, resp_ctrl, xbar_ctrl
  );

  modport master (
    output req_valid, req_sel, resp_ready,
    input  req_ready, resp_valid, resp_ok, resp_err, resp_ctrl, xbar_ctrl
  );
endinterface

// File: rtl/crossbar_route_ctrl_xbar_map_eval.sv
// Combinational model of the 5-switch 4x4 crossbar: control code -> output source map.
module xbar_map_eval
  import crossbar_route_ctrl_pkg::*;
(
  input  logic [CTRL_W-1:0] code_i,
  output logic [SEL_W-1:0]  sel_o
);

  // Every net carries the 2-bit index of the crossbar input it came from.
  logic [1:0] a1, a2, b1, b2, m1, m2, o1, o2, o3, o4;

  always_comb begin
    {a1, a2} = code_i[0] ? {2'd1, 2'd0} : {2'd0, 2'd1};
    {b1, b2} = code_i[3] ? {2'd3, 2'd2} : {2'd2, 2'd3};
    {m1, m2} = code_i[2] ? {b1, a2} : {a2, b1};
    {o1, o2} = code_i[1] ? {m1, a1} : {a1, m1};
    {o3, o4} = code_i[4] ? {b2, m2} : {m2, b2};
    sel_o    = {o4, o3, o2, o1};
  end

endmodule

// File: rtl/crossbar_route_ctrl.sv
// Searches crossbar control codes 0..31 for the requested map, one code per cycle.
// Build macro ROUTE_CACHE_EN adds a one-entry cache of the last successful route.
module crossbar_route_ctrl
  import crossbar_route_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  crossbar_route_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CTRL_W-1:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CTRL_W-1:0] xbar_q, xbar_d;
  logic              ok_q, ok_d;
  logic [1:0]        err_q, err_d;

  logic [SEL_W-1:0]  cand_sel;
  logic              dup, cand_hit, last_code, cache_hit, found;
  logic [CTRL_W-1:0] cache_code;

  xbar_map_eval u_map (
    .code_i (cnt_q),
    .sel_o  (cand_sel)
  );

  assign dup       = sel_has_dup(sel_q);
  assign cand_hit  = (cand_sel == sel_q);
  assign last_code = &cnt_q;
  assign found     = (state_q == ST_SEARCH) && !dup && (cache_hit || cand_hit);

`ifdef ROUTE_CACHE_EN
  logic              cache_vld_q;
  logic [SEL_W-1:0]  cache_sel_q;
  logic [CTRL_W-1:0] cache_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q  <= 1'b0;
      cache_sel_q  <= '0;
      cache_code_q <= '0;
    end else if (found) begin
      cache_vld_q  <= 1'b1;
      cache_sel_q  <= sel_q;
      cache_code_q <= ctrl_d;
    end
  end

  assign cache_hit  = cache_vld_q && (cache_sel_q == sel_q);
  assign cache_code = cache_code_q;
`else
  assign cache_hit  = 1'b0;
  assign cache_code = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = ST_SEARCH;
      ST_SEARCH: if (dup || cache_hit || cand_hit || last_code) state_d = ST_RESP;
      ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_ok    = ok_q;
    bus.resp_err   = err_q;
    bus.resp_ctrl  = ctrl_q;
    bus.xbar_ctrl  = xbar_q;
  end

  // Duplicate check outranks the search; cache outranks the current candidate.
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    ok_d   = ok_q;
    err_d  = err_q;
    ctrl_d = ctrl_q;
    xbar_d = xbar_q;
    if (state_q == ST_IDLE) begin
      if (bus.req_valid) begin
        sel_d = bus.req_sel;
        cnt_d = '0;
      end
    end else if (state_q == ST_SEARCH) begin
      if (dup) begin
        ok_d   = 1'b0;
        err_d  = ERR_DUP;
        ctrl_d = '0;
      end else if (cache_hit || cand_hit) begin
        ok_d   = 1'b1;
        err_d  = ERR_NONE;
        ctrl_d = cache_hit ? cache_code : cnt_q;
        xbar_d = ctrl_d;
      end else if (last_code) begin
        ok_d   = 1'b0;
        err_d  = ERR_UNROUTE;
        ctrl_d = '0;
      end else begin
        cnt_d = cnt_q + CTRL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      ok_q   <= 1'b0;
      err_q  <= ERR_NONE;
      ctrl_q <= '0;
      xbar_q <= '0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      ctrl_q <= ctrl_d;
      xbar_q <= xbar_d;
    end
  end

endmodule

// File: doc/crossbar_route_ctrl.md
CROSSBAR_ROUTE_CTRL -- requirements
Module: crossbar_route_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port list SHALL be:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  req_valid  in  1  route request present
  req_ready  out  1  block can accept a request
  req_sel  in  8  desired map; bits [2k+1:2k] = source index (0=in1..3=in4) for out(k+1)
  resp_valid  out  1  route response present
  resp_ready  in  1  consumer accepts response
  resp_ok  out  1  1 = route found, 0 = failure
  resp_err  out  2  0 none, 1 duplicate source, 2 unroutable
  resp_ctrl  out  5  found control code, 0 on failure
  xbar_ctrl  out  5  registered control driving the 4x4 crossbar

Function
REQ-003 2x2 switch model SHALL be: c=0 pass (o1=i1, o2=i2), c=1 swap.
REQ-004 The 4x4 model SHALL be: S1(in1,in2,c[0])->a1,a2; S2(in3,in4,c[3])->b1,b2; S3(a2,b1,c[2])->m1,m2; S4(a1,m1,c[1])->out1,out2; S5(m2,b2,c[4])->out3,out4.
REQ-005 States SHALL be IDLE, SEARCH and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 On the accept edge T (req_valid & req_ready), req_sel SHALL be latched and the block SHALL leave IDLE.
REQ-007 If latched req_sel repeats any source index, the block SHALL enter RESP with resp_ok=0 and resp_err=1, visible after edge T+1.
REQ-008 SEARCH SHALL evaluate one code per cycle in ascending order from 0; code k SHALL be evaluated at edge T+1+k.
REQ-009 The first code whose model map equals req_sel SHALL be returned with resp_ok=1, resp_ctrl=k, visible after edge T+1+k; the lowest matching code always wins.
REQ-010 If codes 0..31 are exhausted with no match, the block SHALL enter RESP with resp_ok=0 and resp_err=2, visible after edge T+32.
REQ-011 In RESP, resp_valid SHALL be 1 and all resp_* outputs SHALL hold stable until resp_valid & resp_ready, then the block SHALL return to IDLE on that edge.
REQ-012 xbar_ctrl SHALL load resp_ctrl on the edge entering RESP with resp_ok=1, and SHALL hold on failure.
REQ-013 req_valid SHALL be ignored outside IDLE, and a request SHALL NOT be accepted on the same edge that completes a response.
REQ-014 The search counter SHALL be 5 bits, and exhaustion SHALL be detected at count 31 without wrap-around to 0.

Reset
REQ-015 rst SHALL force IDLE immediately, including mid-SEARCH or mid-RESP, and SHALL drop any pending request or response.
REQ-016 Reset values SHALL be: req_ready=1 (one cycle after release, IDLE), resp_valid=0, resp_ok=0, resp_err=0, resp_ctrl=0, xbar_ctrl=0, search counter=0.

Configuration
REQ-017 With macro ROUTE_CACHE_EN defined, the block SHALL hold the last successful {req_sel, code} pair with a valid bit cleared by rst.
REQ-018 With ROUTE_CACHE_EN defined, a request matching the cached req_sel SHALL bypass SEARCH and respond after edge T+1 with the cached code.
REQ-019 With ROUTE_CACHE_EN undefined, there SHALL be no cache storage, and every request SHALL follow REQ-007..REQ-010 timing.

Structure
REQ-020 A shared package SHALL hold: state encoding, error-code constants (ERR_NONE, ERR_DUP, ERR_UNROUTE), and width constants (CTRL_W=5, SEL_W=8).
REQ-021 One combinational sub-module, xbar_map_eval, SHALL map a 5-bit code to the 8-bit sel vector it realises per REQ-003/REQ-004, and the same sub-module SHALL serve as the bench reference model.

Verification
REQ-022 Identity: req_sel=8'hE4 -> resp_ok=1, resp_ctrl=0, resp_valid after T+1, xbar_ctrl=0.
REQ-023 Swap out1/out2: req_sel=8'hE1 -> resp_ctrl=5'd1, resp_valid after T+2.
REQ-024 Swap out3/out4: req_sel=8'hB4 -> resp_ctrl=5'd8 (lowest match, not 16), resp_valid after T+9, xbar_ctrl=8.
REQ-025 Duplicate: req_sel=8'h00 -> resp_ok=0, resp_err=1 after T+1; a permutation with no matching code (found with xbar_map_eval) -> resp_err=2 after T+32, xbar_ctrl unchanged.
REQ-026 Back-pressure and reset: hold resp_ready=0 for 5 cycles -> outputs stable and req_ready=0; assert rst mid-SEARCH -> all outputs at reset values with no response emitted.
REQ-027 With ROUTE_CACHE_EN: repeat 8'hB4 -> resp_ctrl=8 after T+1; after rst, 8'hB4 -> again after T+9.
